// File: rtl/aoi_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin bus arbiter:
// FSM state, pointer type, one-hot encode and rotating-priority pick.
package aoi_arb_pkg;

    localparam int ARB_N = 4;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    typedef logic [1:0]       ptr_t;
    typedef logic [ARB_N-1:0] vec_t;

    function automatic vec_t onehot(input ptr_t idx);
        vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First requester at or after ptr, wrapping 3->0; scanning downward lets the
    // lowest rotated offset win the last assignment.
    function automatic ptr_t rr_pick(input vec_t req, input ptr_t ptr);
        ptr_t pick;
        ptr_t idx;
        pick = ptr;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            idx = ptr + ptr_t'(i);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/aoi_rr_bus_arbiter_if.sv
// Producer-side bus bundle: requests and packed data in, grant and shared
// registered data out.
interface aoi_rr_bus_arbiter_if #(
    parameter int W = 8
);
    import aoi_arb_pkg::*;

    vec_t               req;
    logic [ARB_N*W-1:0] din;
    vec_t               gnt;
    logic [W-1:0]       y;
    logic               vld;

    modport master (output req, output din, input gnt, input y, input vld);
    modport slave  (input req, input din, output gnt, output y, output vld);

endinterface

// File: rtl/aoi22_mux4.sv
// One-hot-select 4:1 mux built as two AOI22 stages followed by a NAND2,
// so it maps directly onto standard cells.
module aoi22_mux4
    import aoi_arb_pkg::*;
#(
    parameter int W = 8
) (
    input  vec_t               sel_i,
    input  logic [ARB_N*W-1:0] din_i,
    output logic [W-1:0]       y_o
);

    logic [W-1:0] n01;
    logic [W-1:0] n23;

    assign n01 = ~((din_i[0*W +: W] & {W{sel_i[0]}}) | (din_i[1*W +: W] & {W{sel_i[1]}}));
    assign n23 = ~((din_i[2*W +: W] & {W{sel_i[2]}}) | (din_i[3*W +: W] & {W{sel_i[3]}}));
    assign y_o = ~(n01 & n23);

endmodule

// File: rtl/aoi_rr_bus_arbiter.sv
// Round-robin owner of a shared W-bit bus with bounded hold under contention,
// registered one-hot grant and registered output data.
module aoi_rr_bus_arbiter
    import aoi_arb_pkg::*;
#(
    parameter int W       = 8,
    parameter int MAXHOLD = 8
) (
    input logic                  clk_i,
    input logic                  rst_i,
    aoi_rr_bus_arbiter_if.slave  bus
);

    localparam int             CW      = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAXHOLD - 1);

    state_e        state_q, state_d;
    ptr_t          ptr_q, ptr_d;
    ptr_t          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    vec_t          gnt_q, gnt_d;
    logic [W-1:0]  y_q, y_d;
    logic          vld_q, vld_d;
    logic [W-1:0]  mux_y;
    logic          contend;

    aoi22_mux4 #(.W(W)) u_mux (
        .sel_i (gnt_q),
        .din_i (bus.din),
        .y_o   (mux_y)
    );

    assign contend = |(bus.req & ~gnt_q);

    always_comb begin
        // NOTE: every output gets a hold default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;

        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    owner_d = rr_pick(bus.req, ptr_q);
                    gnt_d   = onehot(owner_d);
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // Voluntary drop and timeout collapse into one release.
                if (!bus.req[owner_q] || (cnt_q == CNT_MAX && contend)) begin
                    gnt_d   = '0;
                    ptr_d   = owner_q + ptr_t'(1);
                    state_d = IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign vld_d = |(gnt_q & bus.req);
    assign y_d   = vld_d ? mux_y : y_q;

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            y_q     <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.gnt = gnt_q;
    assign bus.y   = y_q;
    assign bus.vld = vld_q;

endmodule

// File: tb/tb_aoi_rr_bus_arbiter.sv
// Directed scenario bench for aoi_rr_bus_arbiter (W=8, MAXHOLD=8).
module tb_aoi_rr_bus_arbiter;
    import aoi_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    aoi_rr_bus_arbiter_if #(.W(8)) bus ();

    aoi_rr_bus_arbiter #(.W(8), .MAXHOLD(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_gnt(input string name, input logic [3:0] exp);
        n_cmp++;
        if (bus.gnt !== exp) begin
            n_bad++;
            $display("FAIL %s gnt: got %b want %b", name, bus.gnt, exp);
        end
    endtask

    task automatic chk_vld(input string name, input logic exp);
        n_cmp++;
        if (bus.vld !== exp) begin
            n_bad++;
            $display("FAIL %s vld: got %b want %b", name, bus.vld, exp);
        end
    endtask

    task automatic chk_y(input string name, input logic [7:0] exp);
        n_cmp++;
        if (bus.y !== exp) begin
            n_bad++;
            $display("FAIL %s y: got %h want %h", name, bus.y, exp);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 4'hF;
        bus.din = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_gnt("reset_hold", 4'b0000);
            chk_vld("reset_hold", 1'b0);
            chk_y("reset_hold", 8'h00);
        end
        rst = 1'b0;
        tick();
        chk_gnt("reset_first", 4'b0001);
        chk_vld("reset_first", 1'b0);
        tick();
        chk_vld("reset_first_data", 1'b1);
        chk_y("reset_first_data", 8'h11);
    endtask

    task automatic test_single();
        apply_reset();
        bus.req = 4'b0100;
        bus.din = {8'h00, 8'hA5, 8'h00, 8'h00};
        tick();
        chk_gnt("single_n1", 4'b0100);
        chk_vld("single_n1", 1'b0);
        tick();
        chk_vld("single_n2", 1'b1);
        chk_y("single_n2", 8'hA5);
    endtask

    task automatic test_rotation();
        logic [3:0] seq_gnt [5];
        logic [7:0] seq_y   [5];
        seq_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_y   = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD0};
        apply_reset();
        bus.req = 4'hF;
        bus.din = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                chk_gnt($sformatf("rot_k%0d_c%0d", k, c), seq_gnt[k]);
                if (c == 0) begin
                    chk_vld($sformatf("rot_k%0d_c%0d", k, c), 1'b0);
                end else begin
                    chk_vld($sformatf("rot_k%0d_c%0d", k, c), 1'b1);
                    chk_y($sformatf("rot_k%0d_c%0d", k, c), seq_y[k]);
                end
            end
            tick();
            chk_gnt($sformatf("rot_k%0d_dead", k), 4'b0000);
            chk_vld($sformatf("rot_k%0d_dead", k), 1'b1);
            chk_y($sformatf("rot_k%0d_dead", k), seq_y[k]);
        end
    endtask

    task automatic test_lone_owner();
        apply_reset();
        bus.req = 4'b0001;
        bus.din = {8'h00, 8'h00, 8'h00, 8'h3C};
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk_gnt($sformatf("lone_c%0d", c), 4'b0001);
            if (c >= 2) chk_vld($sformatf("lone_c%0d", c), 1'b1);
        end
        chk_y("lone_end", 8'h3C);
    endtask

    task automatic test_release_skip();
        apply_reset();
        bus.req = 4'b0010;
        tick();
        chk_gnt("skip_own1", 4'b0010);
        bus.req = 4'b1011;
        tick();
        chk_gnt("skip_hold", 4'b0010);
        bus.req = 4'b1001;
        tick();
        chk_gnt("skip_release", 4'b0000);
        tick();
        chk_gnt("skip_next", 4'b1000);
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        bus.req = 4'b0001;
        tick();
        chk_gnt("midrst_g0", 4'b0001);
        bus.req = 4'b0000;
        tick();
        chk_gnt("midrst_rel0", 4'b0000);
        bus.req = 4'b0100;
        bus.din = {8'h00, 8'h5A, 8'h00, 8'h00};
        tick();
        chk_gnt("midrst_g2", 4'b0100);
        tick();
        chk_vld("midrst_beat", 1'b1);
        chk_y("midrst_beat", 8'h5A);
        rst = 1'b1;
        tick();
        chk_gnt("midrst_rst", 4'b0000);
        chk_vld("midrst_rst", 1'b0);
        chk_y("midrst_rst", 8'h00);
        rst     = 1'b0;
        bus.req = 4'b0011;
        tick();
        chk_gnt("midrst_ptr0", 4'b0001);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b1;
        bus.req = '0;
        bus.din = '0;
        test_reset();
        test_single();
        test_rotation();
        test_lone_owner();
        test_release_skip();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
